cirno9_mem_arb: RTL and testbench

- Shares the single core memory port (the downstream LSU/SRAM/AXI request path) between three requesters: instruction fetch (IFU), data access (EXU address-gen), and an external bus slave (DMA/debug).
- Uses a fixed priority with a starvation escape for the external requester.
- Locks the grant for the whole access and routes the response back to the winner only.
- Sits between the IFU/EXU handshakes and the LSU request port.

---
 rtl/cirno9_mem_arb_pkg.sv | 23 ++
 rtl/cirno9_mem_arb_prio.sv | 22 ++
 rtl/cirno9_mem_arb.sv | 142 ++++++++++++++
 tb/tb_cirno9_mem_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cirno9_mem_arb_pkg.sv
// Shared encodings for the cirno9 memory-port arbiter: grant codes, FSM
// states and the one-hot to grant-code helper.
package cirno9_mem_arb_pkg;

  localparam logic [1:0] CIRNO_GNT_NONE = 2'd0;
  localparam logic [1:0] CIRNO_GNT_IF   = 2'd1;
  localparam logic [1:0] CIRNO_GNT_EX   = 2'd2;
  localparam logic [1:0] CIRNO_GNT_XS   = 2'd3;

  typedef enum logic {
    CIRNO_ARB_IDLE = 1'b0,
    CIRNO_ARB_BUSY = 1'b1
  } arb_state_t;

  // One-hot order is {xs, ex, if}
  function automatic logic [1:0] gnt_enc(input logic [2:0] oh);
    if (oh[2])      return CIRNO_GNT_XS;
    else if (oh[1]) return CIRNO_GNT_EX;
    else if (oh[0]) return CIRNO_GNT_IF;
    else            return CIRNO_GNT_NONE;
  endfunction

endpackage

// File: rtl/cirno9_mem_arb_prio.sv
// Combinational three-way priority picker. The starvation flag lifts the
// external requester above everyone; otherwise data > fetch > external.
module cirno9_mem_arb_prio
  import cirno9_mem_arb_pkg::*;
(
  input  logic       if_val,
  input  logic       ex_val,
  input  logic       xs_val,
  input  logic       starve,
  output logic [2:0] gnt_oh
);

  // Pick exactly one winner among the pending requesters
  always_comb begin
    gnt_oh = 3'b000;
    if (starve && xs_val) gnt_oh = 3'b100;
    else if (ex_val)      gnt_oh = 3'b010;
    else if (if_val)      gnt_oh = 3'b001;
    else if (xs_val)      gnt_oh = 3'b100;
  end

endmodule

// File: rtl/cirno9_mem_arb.sv
// Memory-port arbiter: shares the single LSU request port between fetch,
// data and an external bus slave. The grant is locked for the whole access
// and the completion pulse is routed back to the owner only.
module cirno9_mem_arb
  import cirno9_mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_halt,
  input  logic            hs_if4arb_val,
  output logic            hs_arb4if_rdy,
  input  logic [AW-1:0]   i_if_adr,
  input  logic            hs_ex4arb_val,
  output logic            hs_arb4ex_rdy,
  input  logic [AW-1:0]   i_ex_adr,
  input  logic [DW-1:0]   i_ex_wdat,
  input  logic [DW/8-1:0] i_ex_wen,
  input  logic            i_ex_ren,
  input  logic            hs_xs4arb_val,
  output logic            hs_arb4xs_rdy,
  input  logic [AW-1:0]   i_xs_adr,
  input  logic [DW-1:0]   i_xs_wdat,
  input  logic [DW/8-1:0] i_xs_wen,
  input  logic            i_xs_ren,
  output logic            hs_arb4ls_val,
  input  logic            hs_ls4arb_rdy,
  output logic [AW-1:0]   o_adr,
  output logic [DW-1:0]   o_wdat,
  output logic [DW/8-1:0] o_wen,
  output logic            o_ren,
  input  logic [DW-1:0]   i_rdat,
  output logic [DW-1:0]   o_rdat,
  output logic [1:0]      o_gnt
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  arb_state_t      state;
  logic [1:0]      gnt_q;
  logic            ls_val_q;
  logic [AW-1:0]   adr_q;
  logic [DW-1:0]   wdat_q;
  logic [DW/8-1:0] wen_q;
  logic            ren_q;
  logic [DW-1:0]   rdat_q;
  logic [7:0]      starve_cnt;
  logic [2:0]      win_oh;
  logic            starve;
  logic            done;

  // Saturating increment of the starvation counter
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == STARVE_LIM) ? v : v + 8'd1;
  endfunction

  assign starve = (starve_cnt == STARVE_LIM);
  assign done   = (state == CIRNO_ARB_BUSY) && hs_ls4arb_rdy;

  cirno9_mem_arb_prio u_prio (
    .if_val (hs_if4arb_val),
    .ex_val (hs_ex4arb_val),
    .xs_val (hs_xs4arb_val),
    .starve (starve),
    .gnt_oh (win_oh)
  );

  // Completion pulse and read data go straight through to the owner only
  assign hs_arb4if_rdy = done && (gnt_q == CIRNO_GNT_IF);
  assign hs_arb4ex_rdy = done && (gnt_q == CIRNO_GNT_EX);
  assign hs_arb4xs_rdy = done && (gnt_q == CIRNO_GNT_XS);
  assign o_rdat        = done ? i_rdat : rdat_q;

  assign hs_arb4ls_val = ls_val_q;
  assign o_gnt         = gnt_q;
  assign o_adr         = adr_q;
  assign o_wdat        = wdat_q;
  assign o_wen         = wen_q;
  assign o_ren         = ren_q;

  // Arbitration FSM: latch the winner's payload on grant, hold it until the
  // downstream completion, then spend one IDLE cycle before re-arbitrating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CIRNO_ARB_IDLE;
      gnt_q      <= CIRNO_GNT_NONE;
      ls_val_q   <= 1'b0;
      adr_q      <= '0;
      wdat_q     <= '0;
      wen_q      <= '0;
      ren_q      <= 1'b0;
      rdat_q     <= '0;
      starve_cnt <= 8'd0;
    end else begin
      case (state)
        CIRNO_ARB_IDLE: begin
          if (!i_halt && (|win_oh)) begin
            state    <= CIRNO_ARB_BUSY;
            ls_val_q <= 1'b1;
            gnt_q    <= gnt_enc(win_oh);
            if (win_oh[2]) begin
              adr_q  <= i_xs_adr;
              wdat_q <= i_xs_wdat;
              wen_q  <= i_xs_wen;
              ren_q  <= i_xs_ren;
            end else if (win_oh[1]) begin
              adr_q  <= i_ex_adr;
              wdat_q <= i_ex_wdat;
              wen_q  <= i_ex_wen;
              ren_q  <= i_ex_ren;
            end else begin
              // Fetch is always a plain read
              adr_q  <= i_if_adr;
              wdat_q <= '0;
              wen_q  <= '0;
              ren_q  <= 1'b1;
            end
            if (win_oh[2])          starve_cnt <= 8'd0;
            else if (hs_xs4arb_val) starve_cnt <= sat_inc(starve_cnt);
            else                    starve_cnt <= 8'd0;
          end else if (!i_halt) begin
            // Nothing pending, so the external requester is not waiting
            starve_cnt <= 8'd0;
          end
        end
        CIRNO_ARB_BUSY: begin
          if (hs_ls4arb_rdy) begin
            state    <= CIRNO_ARB_IDLE;
            ls_val_q <= 1'b0;
            gnt_q    <= CIRNO_GNT_NONE;
            rdat_q   <= i_rdat;
          end
        end
        default: state <= CIRNO_ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cirno9_mem_arb.sv
// Bench for cirno9_mem_arb: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_cirno9_mem_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_halt;
  logic            hs_if4arb_val;
  logic            hs_arb4if_rdy;
  logic [AW-1:0]   i_if_adr;
  logic            hs_ex4arb_val;
  logic            hs_arb4ex_rdy;
  logic [AW-1:0]   i_ex_adr;
  logic [DW-1:0]   i_ex_wdat;
  logic [DW/8-1:0] i_ex_wen;
  logic            i_ex_ren;
  logic            hs_xs4arb_val;
  logic            hs_arb4xs_rdy;
  logic [AW-1:0]   i_xs_adr;
  logic [DW-1:0]   i_xs_wdat;
  logic [DW/8-1:0] i_xs_wen;
  logic            i_xs_ren;
  logic            hs_arb4ls_val;
  logic            hs_ls4arb_rdy;
  logic [AW-1:0]   o_adr;
  logic [DW-1:0]   o_wdat;
  logic [DW/8-1:0] o_wen;
  logic            o_ren;
  logic [DW-1:0]   i_rdat;
  logic [DW-1:0]   o_rdat;
  logic [1:0]      o_gnt;

  always #5 clk = ~clk;

  cirno9_mem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .i_halt(i_halt),
    .hs_if4arb_val(hs_if4arb_val), .hs_arb4if_rdy(hs_arb4if_rdy), .i_if_adr(i_if_adr),
    .hs_ex4arb_val(hs_ex4arb_val), .hs_arb4ex_rdy(hs_arb4ex_rdy), .i_ex_adr(i_ex_adr),
    .i_ex_wdat(i_ex_wdat), .i_ex_wen(i_ex_wen), .i_ex_ren(i_ex_ren),
    .hs_xs4arb_val(hs_xs4arb_val), .hs_arb4xs_rdy(hs_arb4xs_rdy), .i_xs_adr(i_xs_adr),
    .i_xs_wdat(i_xs_wdat), .i_xs_wen(i_xs_wen), .i_xs_ren(i_xs_ren),
    .hs_arb4ls_val(hs_arb4ls_val), .hs_ls4arb_rdy(hs_ls4arb_rdy),
    .o_adr(o_adr), .o_wdat(o_wdat), .o_wen(o_wen), .o_ren(o_ren),
    .i_rdat(i_rdat), .o_rdat(o_rdat), .o_gnt(o_gnt)
  );

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: who owns the port, what was latched, last read data
  int              m_own;
  int              m_cnt;
  logic [AW-1:0]   m_adr;
  logic [DW-1:0]   m_wdat;
  logic [DW/8-1:0] m_wen;
  logic            m_ren;
  logic [DW-1:0]   m_rdat;
  logic            m_done [1:3];
  logic            s_rdy  [1:3];
  logic [DW-1:0]   s_rdat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_cnt = 0; m_adr = '0; m_wdat = '0; m_wen = '0; m_ren = 1'b0; m_rdat = '0;
  endtask

  task automatic model_edge();
    int w;
    if (m_own != 0) begin
      if (hs_ls4arb_rdy) begin
        m_own  = 0;
        m_rdat = i_rdat;
      end
    end else if (!i_halt) begin
      if (hs_if4arb_val || hs_ex4arb_val || hs_xs4arb_val) begin
        if (hs_xs4arb_val && m_cnt == SM) w = 3;
        else if (hs_ex4arb_val)           w = 2;
        else if (hs_if4arb_val)           w = 1;
        else                              w = 3;
        if (w == 3)             m_cnt = 0;
        else if (hs_xs4arb_val) m_cnt = (m_cnt < SM) ? m_cnt + 1 : m_cnt;
        else                    m_cnt = 0;
        case (w)
          1: begin m_adr = i_if_adr; m_wdat = '0;        m_wen = '0;       m_ren = 1'b1;     end
          2: begin m_adr = i_ex_adr; m_wdat = i_ex_wdat; m_wen = i_ex_wen; m_ren = i_ex_ren; end
          default: begin m_adr = i_xs_adr; m_wdat = i_xs_wdat; m_wen = i_xs_wen; m_ren = i_xs_ren; end
        endcase
        m_own = w;
      end else begin
        m_cnt = 0;
      end
    end
  endtask

  // One clock: check combinational returns, take the edge, check registers
  task automatic cyc();
    logic fin;
    #1;
    fin = (m_own != 0) && hs_ls4arb_rdy;
    for (int k = 1; k <= 3; k++) m_done[k] = fin && (m_own == k);
    chk("rdy_if", hs_arb4if_rdy, m_done[1]);
    chk("rdy_ex", hs_arb4ex_rdy, m_done[2]);
    chk("rdy_xs", hs_arb4xs_rdy, m_done[3]);
    chk("rdat", o_rdat, fin ? i_rdat : m_rdat);
    s_rdy[1] = hs_arb4if_rdy; s_rdy[2] = hs_arb4ex_rdy; s_rdy[3] = hs_arb4xs_rdy;
    s_rdat = o_rdat;
    @(posedge clk);
    model_edge();
    #1;
    chk("ls_val", hs_arb4ls_val, m_own != 0);
    chk("gnt", o_gnt, m_own[1:0]);
    chk("adr", o_adr, m_adr);
    chk("wdat", o_wdat, m_wdat);
    chk("wen", o_wen, m_wen);
    chk("ren", o_ren, m_ren);
    chk("starve_cnt", dut.starve_cnt, m_cnt[7:0]);
    @(negedge clk);
  endtask

  task automatic quiet();
    hs_if4arb_val = 0; hs_ex4arb_val = 0; hs_xs4arb_val = 0;
    hs_ls4arb_rdy = 0; i_halt = 0;
  endtask

  initial begin
    rst = 1; quiet();
    i_if_adr = '0; i_ex_adr = '0; i_ex_wdat = '0; i_ex_wen = '0; i_ex_ren = 0;
    i_xs_adr = '0; i_xs_wdat = '0; i_xs_wen = '0; i_xs_ren = 0; i_rdat = '0;
    model_reset();
    for (int k = 1; k <= 3; k++) begin m_done[k] = 0; s_rdy[k] = 0; end
    s_rdat = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_ls_val", hs_arb4ls_val, 0);
    chk("rst_gnt", o_gnt, 0);
    chk("rst_adr", o_adr, 0);
    chk("rst_wdat", o_wdat, 0);
    chk("rst_wen", o_wen, 0);
    chk("rst_ren", o_ren, 0);
    chk("rst_rdat", o_rdat, 0);
    chk("rst_rdys", {hs_arb4if_rdy, hs_arb4ex_rdy, hs_arb4xs_rdy}, 0);
    chk("rst_cnt", dut.starve_cnt, 0);
    rst = 0;

    // Single fetch, downstream completes three cycles after val
    hs_if4arb_val = 1; i_if_adr = 32'h0000_0100;
    cyc();
    chk("t1_gnt", o_gnt, 1);
    chk("t1_adr", o_adr, 32'h100);
    chk("t1_ren", o_ren, 1);
    chk("t1_wen", o_wen, 0);
    cyc(); cyc();
    hs_ls4arb_rdy = 1; i_rdat = 32'hDEAD_BEEF;
    cyc();
    chk("t1_rdy_if", s_rdy[1], 1);
    chk("t1_rdat", s_rdat, 32'hDEAD_BEEF);
    hs_if4arb_val = 0; hs_ls4arb_rdy = 0;
    cyc();

    // Fetch and data store together: data first, IDLE gap, then fetch
    hs_if4arb_val = 1; i_if_adr = 32'h0000_0180;
    hs_ex4arb_val = 1; i_ex_adr = 32'h0000_0040; i_ex_wen = 4'hF;
    i_ex_wdat = 32'h1234_5678; i_ex_ren = 0;
    cyc();
    chk("t2_gnt_ex", o_gnt, 2);
    chk("t2_wen", o_wen, 4'hF);
    chk("t2_wdat", o_wdat, 32'h1234_5678);
    hs_ls4arb_rdy = 1; i_rdat = 32'h0;
    cyc();
    chk("t2_rdy_ex", s_rdy[2], 1);
    hs_ex4arb_val = 0; hs_ls4arb_rdy = 0;
    cyc();
    chk("t2_gap_gnt", o_gnt, 1);
    hs_ls4arb_rdy = 1; i_rdat = 32'h0BAD_F00D;
    cyc();
    hs_if4arb_val = 0; hs_ls4arb_rdy = 0;
    cyc();

    // Starvation: data keeps re-requesting, external wins the 4th arbitration
    hs_ex4arb_val = 1; i_ex_wen = 4'h0; i_ex_ren = 1; i_ex_adr = 32'h0000_0044;
    hs_xs4arb_val = 1; i_xs_adr = 32'h8000_0000; i_xs_wen = 4'h3;
    i_xs_wdat = 32'hCAFE_0001; i_xs_ren = 0;
    hs_ls4arb_rdy = 1;
    for (int i = 0; i < 6; i++) cyc();
    chk("t3_cnt_before", dut.starve_cnt, SM);
    cyc();
    chk("t3_gnt_xs", o_gnt, 3);
    chk("t3_cnt_after", dut.starve_cnt, 0);
    cyc();
    chk("t3_rdy_xs", s_rdy[3], 1);
    quiet();
    cyc();

    // Halt during a BUSY data access
    hs_ex4arb_val = 1; i_ex_adr = 32'h0000_0400; i_ex_wen = 4'h0; i_ex_ren = 1;
    cyc();
    i_halt = 1; hs_if4arb_val = 1; i_if_adr = 32'h0000_0500;
    cyc();
    hs_ls4arb_rdy = 1; i_rdat = 32'h5555_AAAA;
    cyc();
    chk("t4_rdy_ex", s_rdy[2], 1);
    hs_ex4arb_val = 0; hs_ls4arb_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_halt_gnt", o_gnt, 0);
    end
    i_halt = 0;
    cyc();
    chk("t4_gnt_if", o_gnt, 1);
    hs_ls4arb_rdy = 1;
    cyc();
    quiet();
    cyc();

    // Reset pulsed while an external write is in flight
    hs_xs4arb_val = 1; i_xs_adr = 32'h9000_0010; i_xs_wen = 4'hF;
    i_xs_wdat = 32'h7777_1111; i_xs_ren = 0;
    cyc();
    chk("t5_gnt_xs", o_gnt, 3);
    hs_ls4arb_rdy = 1;
    #2 rst = 1;
    #1;
    chk("t5_rst_val", hs_arb4ls_val, 0);
    chk("t5_rst_gnt", o_gnt, 0);
    chk("t5_rst_rdy_xs", hs_arb4xs_rdy, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0; hs_ls4arb_rdy = 0;
    cyc();
    chk("t5_regrant", o_gnt, 3);
    chk("t5_regrant_adr", o_adr, 32'h9000_0010);
    hs_ls4arb_rdy = 1;
    cyc();
    quiet();
    cyc();

    // Payload changes during BUSY are ignored
    hs_ex4arb_val = 1; i_ex_adr = 32'h0000_0200; i_ex_ren = 1; i_ex_wen = 4'h0;
    cyc();
    i_ex_adr = 32'h0000_0300;
    cyc(); cyc();
    chk("t6_adr_held", o_adr, 32'h200);
    hs_ls4arb_rdy = 1;
    cyc();
    quiet();
    cyc();

    // Random traffic that honours the hold-until-rdy contract
    for (int n = 0; n < 600; n++) begin
      if (m_done[1]) hs_if4arb_val = 0;
      if (m_done[2]) hs_ex4arb_val = 0;
      if (m_done[3]) hs_xs4arb_val = 0;
      if (!hs_if4arb_val && $urandom_range(0, 2) == 0) begin
        hs_if4arb_val = 1; i_if_adr = $urandom;
      end
      if (!hs_ex4arb_val && $urandom_range(0, 2) == 0) begin
        hs_ex4arb_val = 1; i_ex_adr = $urandom; i_ex_wdat = $urandom;
        i_ex_wen = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        i_ex_ren = (i_ex_wen == 4'h0);
      end
      if (!hs_xs4arb_val && $urandom_range(0, 1) == 0) begin
        hs_xs4arb_val = 1; i_xs_adr = $urandom; i_xs_wdat = $urandom;
        i_xs_wen = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        i_xs_ren = (i_xs_wen == 4'h0);
      end
      i_halt = ($urandom_range(0, 9) == 0);
      hs_ls4arb_rdy = ($urandom_range(0, 1) == 1);
      i_rdat = $urandom;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
